control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for an 8-bit accumulator machine (LDA/ADD/SUB/OUT/HLT).
// State advances on posedge clk; control outputs decode state and opcode combinationally (zero latency).
// No backpressure: one T-state per clock, HLT parks the block until rst.
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_oe,
  output logic       mar_ie,
  output logic       ram_oe,
  output logic       ir_ie,
  output logic       ir_oe,
  output logic       a_ie,
  output logic       a_oe,
  output logic       b_ie,
  output logic       alu_sub,
  output logic       alu_oe,
  output logic       out_ie,
  output logic       halt,
  output logic [2:0] tstate,
  output logic       instr_done
);

  // Encoding doubles as the externally visible tstate value.
  typedef enum logic [2:0] {
    ST_RST = 3'd0,
    ST_T1  = 3'd1,
    ST_T2  = 3'd2,
    ST_T3  = 3'd3,
    ST_T4  = 3'd4,
    ST_T5  = 3'd5,
    ST_T6  = 3'd6,
    ST_HLT = 3'd7
  } state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Power-up value so the block sits in RST before the first reset pulse.
  state_e state_q = ST_RST;
  state_e state_d;

  // Next-state: fixed T-state ring, HLT decided at T4 once the opcode is stable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST: state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2:  state_d = ST_T3;
      ST_T3:  state_d = ST_T4;
      ST_T4:  state_d = (opcode == OP_HLT) ? ST_HLT : ST_T5;
      ST_T5:  state_d = ST_T6;
      ST_T6:  state_d = ST_T1;
      ST_HLT: state_d = ST_HLT;
      default: state_d = ST_RST;
    endcase
  end

  // State register; synchronous reset overrides every transition, including HLT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Control decode: fetch in T1..T3, opcode-specific execute in T4..T6.
  // Opcode is only consulted in T4..T6, so it cannot disturb fetch or idle states.
  always_comb begin
    pc_inc  = 1'b0;
    pc_oe   = 1'b0;
    mar_ie  = 1'b0;
    ram_oe  = 1'b0;
    ir_ie   = 1'b0;
    ir_oe   = 1'b0;
    a_ie    = 1'b0;
    a_oe    = 1'b0;
    b_ie    = 1'b0;
    alu_sub = 1'b0;
    alu_oe  = 1'b0;
    out_ie  = 1'b0;
    case (state_q)
      ST_T1: begin
        pc_oe  = 1'b1;
        mar_ie = 1'b1;
      end
      ST_T2: begin
        pc_inc = 1'b1;
      end
      ST_T3: begin
        ram_oe = 1'b1;
        ir_ie  = 1'b1;
      end
      ST_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            // Operand nibble becomes the data address.
            ir_oe  = 1'b1;
            mar_ie = 1'b1;
          end
          OP_OUT: begin
            a_oe   = 1'b1;
            out_ie = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (opcode)
          OP_LDA: begin
            ram_oe = 1'b1;
            a_ie   = 1'b1;
          end
          OP_ADD: begin
            ram_oe = 1'b1;
            b_ie   = 1'b1;
          end
          OP_SUB: begin
            // alu_sub set early so the ALU result settles before T6 writes A.
            ram_oe  = 1'b1;
            b_ie    = 1'b1;
            alu_sub = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (opcode)
          OP_ADD: begin
            alu_oe = 1'b1;
            a_ie   = 1'b1;
          end
          OP_SUB: begin
            alu_oe  = 1'b1;
            a_ie    = 1'b1;
            alu_sub = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign halt       = (state_q == ST_HLT);
  assign instr_done = (state_q == ST_T6);
  assign tstate     = state_q;

endmodule
